button_input: RTL and testbench

//  Input-side companion to the board LED outputs: conditions the evaluation-board push-buttons/DIP switches.
//  Per channel: synchronize, debounce, provide level and edge pulses.

---
 rtl/button_input_pkg.sv | 14 +
 rtl/button_debounce.sv | 65 ++++++
 rtl/button_input.sv | 179 +++++++++++++++++
 tb/tb_button_input.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_input_pkg.sv
// Shared definitions for the push-button / DIP-switch input conditioner.
// Event direction encodings, the board clock rate and the event code width helper.
package button_input_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  localparam real CLK_12MHZ_FREQUENCY = 12.0e6;

  function automatic int evt_width(input int w);
    return 1 + $clog2(w);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One debounce channel: the synchronized, polarity-normalized input must disagree with
// the held state for DEBOUNCE_TICKS consecutive ticks before the state flips.
module button_debounce
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rstN,
  input  logic sync_in,
  input  logic tick,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Counter, state toggle and edge pulses; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_in == state_q) begin
      cnt_d = CW'(0);
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        state_d   = ~state_q;
        cnt_d     = CW'(0);
        press_d   = ~state_q;
        release_d = state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q     <= CW'(0);
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_input.sv
// Board button/switch conditioner: 2-flop synchronizers, shared debounce tick,
// per-channel debounce, and a single valid/ready event stream of queued edges.
module button_input
  import button_input_pkg::*;
#(
  parameter int  WIDTH          = 4,
  parameter real CLK_FREQUENCY  = CLK_12MHZ_FREQUENCY,
  parameter real TICK_PERIOD    = 1.0e-3,
  parameter int  DEBOUNCE_TICKS = 10,
  parameter bit  ACTIVE_LOW     = 1'b1,
  parameter bit  USEIOFF        = 1'b1
) (
  input  logic                         clk_12mhz,
  input  logic                         rstN,
  input  logic [WIDTH-1:0]             btn_in,
  output logic [WIDTH-1:0]             btn_state,
  output logic [WIDTH-1:0]             btn_press,
  output logic [WIDTH-1:0]             btn_release,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [evt_width(WIDTH)-1:0]  event_code,
  output logic                         event_overflow
);

  localparam int   TICK_CYCLES = int'(CLK_FREQUENCY * TICK_PERIOD);
  localparam int   PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int   EW          = evt_width(WIDTH);
  localparam int   IDXW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic PIN_IDLE    = ACTIVE_LOW;

  function automatic logic [IDXW-1:0] first_set(input logic [WIDTH-1:0] v);
    first_set = IDXW'(0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        first_set = IDXW'(i);
      end
    end
  endfunction

  function automatic logic [EW-1:0] make_code(input logic dir, input logic [IDXW-1:0] idx);
    make_code         = EW'(idx);
    make_code[EW-1]   = dir;
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_s;
  logic [WIDTH-1:0] sync1_s, sync2_q, sync_norm_s;

  logic [WIDTH-1:0] pend_press_q, pend_press_d;
  logic [WIDTH-1:0] pend_release_q, pend_release_d;
  logic [WIDTH-1:0] eff_press_s, eff_release_s;
  logic [WIDTH-1:0] clr_press_s, clr_release_s;
  logic [IDXW-1:0]  sel_idx_s;
  logic             load_s;
  logic             event_valid_q, event_valid_d;
  logic [EW-1:0]    event_code_q, event_code_d;
  logic             overflow_q, overflow_d;

  // Debounce sample prescaler.
  always_comb begin
    tick_s = (presc_q == PW'(TICK_CYCLES - 1));
    if (tick_s) begin
      presc_d = PW'(0);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // First synchronizer stage, optionally packed into the pad register.
  generate
    if (USEIOFF) begin : g_ioff
      (* syn_useioff = 1 *) logic [WIDTH-1:0] sync1_q;
      always_ff @(posedge clk_12mhz or negedge rstN) begin
        if (!rstN) begin
          sync1_q <= {WIDTH{PIN_IDLE}};
        end else begin
          sync1_q <= btn_in;
        end
      end
      assign sync1_s = sync1_q;
    end else begin : g_fabric
      logic [WIDTH-1:0] sync1_q;
      always_ff @(posedge clk_12mhz or negedge rstN) begin
        if (!rstN) begin
          sync1_q <= {WIDTH{PIN_IDLE}};
        end else begin
          sync1_q <= btn_in;
        end
      end
      assign sync1_s = sync1_q;
    end
  endgenerate

  // Polarity normalization: 1 always means pressed from here on.
  always_comb begin
    if (ACTIVE_LOW) begin
      sync_norm_s = ~sync2_q;
    end else begin
      sync_norm_s = sync2_q;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      button_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_debounce (
        .clk       (clk_12mhz),
        .rstN      (rstN),
        .sync_in   (sync_norm_s[i]),
        .tick      (tick_s),
        .state_o   (btn_state[i]),
        .press_o   (btn_press[i]),
        .release_o (btn_release[i])
      );
    end
  endgenerate

  // Event selection: fresh pulses bypass the pending bits so an idle stream answers in one cycle.
  always_comb begin
    eff_press_s   = pend_press_q | btn_press;
    eff_release_s = pend_release_q | btn_release;
    load_s        = !event_valid_q || event_ready;
    clr_press_s   = {WIDTH{1'b0}};
    clr_release_s = {WIDTH{1'b0}};
    sel_idx_s     = IDXW'(0);
    event_valid_d = event_valid_q;
    event_code_d  = event_code_q;
    if (load_s) begin
      if (|eff_press_s) begin
        sel_idx_s     = first_set(eff_press_s);
        clr_press_s   = WIDTH'(1) << sel_idx_s;
        event_valid_d = 1'b1;
        event_code_d  = make_code(EVT_PRESS, sel_idx_s);
      end else if (|eff_release_s) begin
        sel_idx_s     = first_set(eff_release_s);
        clr_release_s = WIDTH'(1) << sel_idx_s;
        event_valid_d = 1'b1;
        event_code_d  = make_code(EVT_RELEASE, sel_idx_s);
      end else begin
        event_valid_d = 1'b0;
      end
    end else begin
      event_valid_d = event_valid_q;
    end
    // A pulse landing on a bit being consumed this cycle is a new event and keeps the bit set.
    pend_press_d   = (eff_press_s & ~clr_press_s) | (pend_press_q & btn_press & clr_press_s);
    pend_release_d = (eff_release_s & ~clr_release_s) | (pend_release_q & btn_release & clr_release_s);
    overflow_d     = overflow_q
                   | (|(pend_press_q & btn_press & ~clr_press_s))
                   | (|(pend_release_q & btn_release & ~clr_release_s));
  end

  // Prescaler, second sync stage, pending bits and event register.
  always_ff @(posedge clk_12mhz or negedge rstN) begin
    if (!rstN) begin
      presc_q        <= PW'(0);
      sync2_q        <= {WIDTH{PIN_IDLE}};
      pend_press_q   <= {WIDTH{1'b0}};
      pend_release_q <= {WIDTH{1'b0}};
      event_valid_q  <= 1'b0;
      event_code_q   <= EW'(0);
      overflow_q     <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      sync2_q        <= sync1_s;
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
      event_valid_q  <= event_valid_d;
      event_code_q   <= event_code_d;
      overflow_q     <= overflow_d;
    end
  end

  assign event_valid    = event_valid_q;
  assign event_code     = event_code_q;
  assign event_overflow = overflow_q;

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: expected event codes are queued when pins are driven
// and compared when the event stream hands them over.
module tb_button_input;

  localparam int W = 4;

  logic         clk_12mhz;
  logic         rstN;
  logic [W-1:0] btn_in;
  logic [W-1:0] btn_state, btn_press, btn_release;
  logic         event_valid, event_ready, event_overflow;
  logic [2:0]   event_code;

  int           pass_cnt;
  int           chk_cnt;
  int           cyc;
  int           press_cnt [W];
  int           rel_cnt   [W];
  int           first_press2;
  logic [2:0]   exp_q [$];
  logic [2:0]   exp_code;

  button_input #(
    .WIDTH          (4),
    .CLK_FREQUENCY  (12.0e6),
    .TICK_PERIOD    (1.0e-6),
    .DEBOUNCE_TICKS (4),
    .ACTIVE_LOW     (1'b1),
    .USEIOFF        (1'b1)
  ) dut (
    .clk_12mhz      (clk_12mhz),
    .rstN           (rstN),
    .btn_in         (btn_in),
    .btn_state      (btn_state),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_code     (event_code),
    .event_overflow (event_overflow)
  );

  initial clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  initial cyc = 0;
  always @(posedge clk_12mhz) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt = chk_cnt + 1;
    if (got == exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pulse bookkeeping and scoreboard pops on every accepted event.
  always @(negedge clk_12mhz) begin
    for (int i = 0; i < W; i++) begin
      if (btn_press[i])   press_cnt[i] = press_cnt[i] + 1;
      if (btn_release[i]) rel_cnt[i]   = rel_cnt[i] + 1;
    end
    if (btn_press[2] && first_press2 < 0) first_press2 = cyc;
    if (rstN && event_valid && event_ready) begin
      check_eq("evt_expected", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        exp_code = exp_q.pop_front();
        check_eq("evt_code", int'(event_code), int'(exp_code));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_12mhz);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || event_valid) && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, (exp_q.size() == 0 && !event_valid) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int base_p, base_r, base2;
    int unstable;
    pass_cnt     = 0;
    chk_cnt      = 0;
    first_press2 = -1;
    for (int i = 0; i < W; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    rstN        = 1'b0;
    btn_in      = 4'hF;
    event_ready = 1'b1;

    // 1: reset and idle pins
    step(3);
    check_eq("rst_outputs", int'({btn_state, btn_press, btn_release, event_valid, event_code, event_overflow}), 0);
    rstN = 1'b1;
    step(1000);
    check_eq("idle_state", int'(btn_state), 0);
    check_eq("idle_pulses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                          + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
    check_eq("idle_valid", int'(event_valid), 0);
    check_eq("idle_overflow", int'(event_overflow), 0);

    // 2: single press on channel 2, latency window
    exp_q.push_back(3'b110);
    lat = cyc;
    btn_in[2] = 1'b0;
    step(70);
    lat = first_press2 - lat;
    check_eq("press2_window", (first_press2 >= 0 && lat >= 39 && lat <= 51) ? 1 : 0, 1);
    check_eq("press2_count", press_cnt[2], 1);
    check_eq("press2_state", int'(btn_state), 4);
    drain("press2_drain", 20);
    exp_q.push_back(3'b010);
    btn_in[2] = 1'b1;
    step(70);
    check_eq("release2_count", rel_cnt[2], 1);
    drain("release2_drain", 20);

    // 3: bouncing channel 1 settles low
    base_p = press_cnt[1];
    base_r = rel_cnt[1];
    exp_q.push_back(3'b101);
    repeat (25) begin
      btn_in[1] = ~btn_in[1];
      step(20);
    end
    check_eq("bounce_no_press", press_cnt[1] - base_p, 0);
    step(80);
    check_eq("bounce_one_press", press_cnt[1] - base_p, 1);
    check_eq("bounce_no_release", rel_cnt[1] - base_r, 0);
    check_eq("bounce_state", int'(btn_state[1]), 1);
    drain("bounce_drain", 20);
    exp_q.push_back(3'b001);
    btn_in[1] = 1'b1;
    step(70);
    drain("ch1_release_drain", 20);

    // 4: simultaneous presses under backpressure
    event_ready = 1'b0;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b111);
    btn_in[0] = 1'b0;
    btn_in[3] = 1'b0;
    step(60);
    check_eq("bp_valid", int'(event_valid), 1);
    check_eq("bp_code_first", int'(event_code), 3'b100);
    unstable = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (!event_valid || event_code != 3'b100) unstable++;
    end
    check_eq("bp_code_stable", unstable, 0);
    event_ready = 1'b1;
    drain("bp_drain", 20);
    check_eq("bp_state", int'(btn_state), 4'b1001);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b011);
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    step(70);
    drain("bp_release_drain", 20);
    check_eq("no_overflow_yet", int'(event_overflow), 0);

    // 5: coalescing on channel 1 while the stream is stalled
    event_ready = 1'b0;
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b001);
    for (int i = 0; i < 5; i++) begin
      btn_in[1] = ~btn_in[1];
      step(100);
    end
    check_eq("ovf_set", int'(event_overflow), 1);
    event_ready = 1'b1;
    drain("ovf_drain", 20);
    check_eq("ovf_sticky", int'(event_overflow), 1);
    exp_q.push_back(3'b001);
    btn_in[1] = 1'b1;
    step(70);
    drain("ovf_release_drain", 20);

    // 6: reset mid-debounce
    base2 = press_cnt[2];
    btn_in[2] = 1'b0;
    step(30);
    #2;
    rstN = 1'b0;
    #1;
    check_eq("midrst_outputs", int'({btn_state, btn_press, btn_release, event_valid, event_code, event_overflow}), 0);
    btn_in[2] = 1'b1;
    step(5);
    rstN = 1'b1;
    step(200);
    check_eq("midrst_no_press", press_cnt[2] - base2, 0);
    check_eq("midrst_state", int'(btn_state), 0);
    check_eq("midrst_valid", int'(event_valid), 0);
    check_eq("midrst_overflow", int'(event_overflow), 0);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
